// File: rtl/program_loader.sv
// Program loader: streams PROG_LEN bytes into the CPU program memory, verifies a
// trailing mod-256 checksum byte, and releases the CPU from reset only on a match.
module program_loader #(
    parameter int PROG_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       prog_we,
    output logic [3:0] prog_addr,
    output logic [7:0] prog_data,
    output logic       cpu_reset,
    output logic       done,
    output logic       cksum_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'(PROG_LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic [7:0] sum;
    logic       accept;
    logic       start_load;

    // Outputs decode from the state register alone, so there is no input-to-output path.
    assign in_ready   = (state == LOAD) || (state == CHECK);
    assign cpu_reset  = (state != RUN);
    assign done       = (state == RUN);
    assign cksum_err  = (state == ERROR);

    assign accept     = in_valid && in_ready;
    assign start_load = start && ((state == IDLE) || (state == RUN) || (state == ERROR));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE, RUN, ERROR: if (start) state_next = LOAD;
            LOAD:             if (accept && (count == LAST_INDEX)) state_next = CHECK;
            CHECK:            if (accept) state_next = (in_data == sum) ? RUN : ERROR;
            default:          state_next = IDLE;
        endcase
    end

    // The write strobe trails the accepted byte by one cycle; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            sum       <= '0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            prog_we <= 1'b0;
            if (start_load) begin
                count <= '0;
                sum   <= '0;
            end else if (accept && (state == LOAD)) begin
                prog_we   <= 1'b1;
                prog_addr <= count;
                prog_data <= in_data;
                sum       <= sum + in_data;
                if (count != LAST_INDEX) count <= count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a PROG_LEN=4 and a PROG_LEN=16 instance share
// stimulus; a scoreboard queue holds expected memory writes popped by a write monitor.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       r4_ready, r4_we, r4_cpu, r4_done, r4_err;
    logic [3:0] r4_addr;
    logic [7:0] r4_data;
    logic       r16_ready, r16_we, r16_cpu, r16_done, r16_err;
    logic [3:0] r16_addr;
    logic [7:0] r16_data;

    logic       m_ready, m_we, m_cpu, m_done, m_err;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    bit          sel16 = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          idx = 0;
    logic [7:0]  model_sum = 8'h00;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader #(.PROG_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r4_ready), .prog_we(r4_we), .prog_addr(r4_addr), .prog_data(r4_data),
        .cpu_reset(r4_cpu), .done(r4_done), .cksum_err(r4_err)
    );

    program_loader #(.PROG_LEN(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r16_ready), .prog_we(r16_we), .prog_addr(r16_addr), .prog_data(r16_data),
        .cpu_reset(r16_cpu), .done(r16_done), .cksum_err(r16_err)
    );

    always_comb begin
        m_ready = sel16 ? r16_ready : r4_ready;
        m_we    = sel16 ? r16_we    : r4_we;
        m_cpu   = sel16 ? r16_cpu   : r4_cpu;
        m_done  = sel16 ? r16_done  : r4_done;
        m_err   = sel16 ? r16_err   : r4_err;
        m_addr  = sel16 ? r16_addr  : r4_addr;
        m_data  = sel16 ? r16_data  : r4_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_we", {m_addr, m_data}, 12'h000);
            else check("write", {m_addr, m_data}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, m_ready, 1'b0);
        check({tag, "_we"},    m_we,    1'b0);
        check({tag, "_addr"},  m_addr,  4'h0);
        check({tag, "_data"},  m_data,  8'h00);
        check({tag, "_cpu"},   m_cpu,   1'b1);
        check({tag, "_done"},  m_done,  1'b0);
        check({tag, "_err"},   m_err,   1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        model_sum = 8'h00;
    endtask

    task automatic send_prog(input logic [7:0] b);
        exp_q.push_back({4'(idx), b});
        idx++;
        model_sum = model_sum + b;
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_base4();
        send_prog(8'hA0); send_prog(8'h01); send_prog(8'h02); send_prog(8'h03);
    endtask

    task automatic expect_run(input string tag);
        check({tag, "_done"},  m_done,  1'b1);
        check({tag, "_cpu"},   m_cpu,   1'b0);
        check({tag, "_err"},   m_err,   1'b0);
        check({tag, "_ready"}, m_ready, 1'b0);
    endtask

    task automatic drain(input string tag);
        tick();
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset state and the basic pass case
        do_reset();
        check_reset_outputs("rst");
        tick();
        check("idle_ready", m_ready, 1'b0);
        do_start();
        check("load_ready", m_ready, 1'b1);
        check("load_cpu", m_cpu, 1'b1);
        send_base4();
        check("check_ready", m_ready, 1'b1);
        check("check_done", m_done, 1'b0);
        check("model_sum", model_sum, 8'hA6);
        send_raw(8'hA6);
        expect_run("pass");
        drain("pass");

        // Checksum mismatch, then restart from ERROR
        do_reset();
        do_start();
        send_base4();
        send_raw(8'hA7);
        check("bad_err", m_err, 1'b1);
        check("bad_cpu", m_cpu, 1'b1);
        check("bad_done", m_done, 1'b0);
        check("bad_ready", m_ready, 1'b0);
        do_start();
        check("restart_err", m_err, 1'b0);
        check("restart_ready", m_ready, 1'b1);
        drain("bad");

        // Gap of three idle cycles between bytes 1 and 2
        do_reset();
        do_start();
        send_prog(8'hA0); send_prog(8'h01);
        tick(); tick(); tick();
        check("gap_ready", m_ready, 1'b1);
        send_prog(8'h02); send_prog(8'h03);
        send_raw(8'hA6);
        expect_run("gap");
        drain("gap");

        // Reset mid-LOAD with a byte presented in the reset cycle
        do_reset();
        do_start();
        send_prog(8'hA0); send_prog(8'h01);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check_reset_outputs("midrst");
        drain("midrst");
        do_start();
        send_base4();
        send_raw(8'hA6);
        expect_run("after_rst");
        drain("after_rst");

        // start ignored in LOAD, honoured in RUN
        do_reset();
        do_start();
        send_prog(8'hA0); send_prog(8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_load_ready", m_ready, 1'b1);
        send_prog(8'h02); send_prog(8'h03);
        send_raw(8'hA6);
        expect_run("run1");
        do_start();
        check("rerun_cpu", m_cpu, 1'b1);
        check("rerun_done", m_done, 1'b0);
        check("rerun_ready", m_ready, 1'b1);
        send_base4();
        send_raw(8'hA6);
        expect_run("run2");
        drain("run2");

        // PROG_LEN=16: sixteen 0x20 bytes wrap the sum to 00
        sel16 = 1'b1;
        do_reset();
        check_reset_outputs("rst16");
        do_start();
        for (int i = 0; i < 16; i++) send_prog(8'h20);
        check("p16_check_ready", m_ready, 1'b1);
        check("p16_sum", model_sum, 8'h00);
        send_raw(8'h00);
        expect_run("p16");
        check("p16_last_addr", m_addr, 4'hF);
        drain("p16");
        check("p16_addr_hold", m_addr, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
